// File: rtl/tile_scheduler.sv
// rtl/tile_scheduler.sv - walks the K-tile / row-block / D-tile loop nest for one layer
// and issues one tile command per valid/ready handshake.
module tile_scheduler #(
  parameter int IDX_W = 11,
  parameter int DIM_W = 7,
  parameter int N_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       layer_type_i,
  input  logic [IDX_W-1:0] in_D_i,
  input  logic [IDX_W-1:0] out_K_i,
  input  logic [DIM_W-1:0] tile_D_i,
  input  logic [DIM_W-1:0] tile_K_i,
  input  logic [DIM_W-1:0] out_R_i,
  input  logic [DIM_W-1:0] out_C_i,
  input  logic [N_W-1:0]   tile_n_i,
  output logic             tile_valid_o,
  input  logic             tile_ready_i,
  output logic [IDX_W-1:0] k_idx_o,
  output logic [IDX_W-1:0] d_idx_o,
  output logic [DIM_W-1:0] cur_K_o,
  output logic [DIM_W-1:0] cur_D_o,
  output logic [DIM_W-1:0] row_start_o,
  output logic [DIM_W-1:0] rows_o,
  output logic             first_d_o,
  output logic             last_d_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam int CNT_W = $clog2(N_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, ISSUE, DONE} state_t;

  state_t state, state_nx;

  logic [1:0]       type_q;
  logic [IDX_W-1:0] in_d_q, out_k_q;
  logic [DIM_W-1:0] tile_d_q, tile_k_q, out_r_q, out_c_q;
  logic [N_W-1:0]   quo_q;
  logic [DIM_W-1:0] rem_q;
  logic [CNT_W-1:0] div_cnt;
  logic [DIM_W-1:0] rpt_q;
  logic [IDX_W-1:0] k_q, d_q;
  logic [DIM_W-1:0] row_q;
  logic             err_q;

  logic             zero_dim, is_dw, issue, fire, cmd_last, div_done;
  logic [DIM_W:0]   div_shift;
  logic             div_ge;
  logic [DIM_W-1:0] div_diff, rem_nx;
  logic [N_W-1:0]   quo_nx;
  logic             q_big;
  logic [DIM_W-1:0] rpt_nx;
  logic [IDX_W:0]   tile_k_x, tile_d_x, k_left, d_left, k_sum, d_sum;
  logic [DIM_W:0]   r_left, r_sum;
  logic [DIM_W-1:0] cur_k, cur_d, rows;
  logic             k_last, r_last, d_last, last_d, first_d;

  assign zero_dim = (in_D_i == '0) || (out_K_i == '0) || (tile_D_i == '0) ||
                    (tile_K_i == '0) || (out_R_i == '0) || (out_C_i == '0);
  assign is_dw    = (type_q == 2'd1);
  assign issue    = (state == ISSUE);
  assign fire     = issue && tile_ready_i;
  assign div_done = (div_cnt == CNT_W'(N_W));

  // One restoring-division step per cycle: quotient bits shift in at the bottom
  // of quo_q as the dividend bits shift out of its top.
  assign div_shift = {rem_q, quo_q[N_W-1]};
  assign div_ge    = (div_shift >= {1'b0, out_c_q});
  assign div_diff  = div_shift[DIM_W-1:0] - out_c_q;
  assign rem_nx    = div_ge ? div_diff : div_shift[DIM_W-1:0];
  assign quo_nx    = {quo_q[N_W-2:0], div_ge};

  assign q_big  = (quo_q > {{(N_W-DIM_W){1'b0}}, out_r_q});
  assign rpt_nx = (quo_q == '0) ? DIM_W'(1) : (q_big ? out_r_q : quo_q[DIM_W-1:0]);

  assign tile_k_x = {{(IDX_W+1-DIM_W){1'b0}}, tile_k_q};
  assign tile_d_x = {{(IDX_W+1-DIM_W){1'b0}}, tile_d_q};
  assign k_left   = {1'b0, out_k_q} - {1'b0, k_q};
  assign d_left   = {1'b0, in_d_q} - {1'b0, d_q};
  assign k_sum    = {1'b0, k_q} + tile_k_x;
  assign d_sum    = {1'b0, d_q} + tile_d_x;
  assign r_left   = {1'b0, out_r_q} - {1'b0, row_q};
  assign r_sum    = {1'b0, row_q} + {1'b0, rpt_q};

  assign cur_k   = (tile_k_x < k_left) ? tile_k_q : k_left[DIM_W-1:0];
  assign cur_d   = (tile_d_x < d_left) ? tile_d_q : d_left[DIM_W-1:0];
  assign rows    = ({1'b0, rpt_q} < r_left) ? rpt_q : r_left[DIM_W-1:0];
  assign k_last  = (k_sum >= {1'b0, out_k_q});
  assign r_last  = (r_sum >= {1'b0, out_r_q});
  assign d_last  = (d_sum >= {1'b0, in_d_q});
  assign last_d  = is_dw || d_last;
  assign first_d = is_dw || (d_q == '0);

  assign cmd_last = fire && last_d && r_last && k_last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_i) state_nx = zero_dim ? DONE : CALC;
      CALC:    if (div_done) state_nx = ISSUE;
      ISSUE:   if (cmd_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      type_q   <= '0;
      in_d_q   <= '0;
      out_k_q  <= '0;
      tile_d_q <= '0;
      tile_k_q <= '0;
      out_r_q  <= '0;
      out_c_q  <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      div_cnt  <= '0;
      rpt_q    <= '0;
      k_q      <= '0;
      d_q      <= '0;
      row_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            type_q   <= layer_type_i;
            in_d_q   <= in_D_i;
            out_k_q  <= out_K_i;
            tile_d_q <= tile_D_i;
            tile_k_q <= tile_K_i;
            out_r_q  <= out_R_i;
            out_c_q  <= out_C_i;
            quo_q    <= tile_n_i;
            rem_q    <= '0;
            div_cnt  <= '0;
            k_q      <= '0;
            d_q      <= '0;
            row_q    <= '0;
            err_q    <= zero_dim;
          end
        end
        CALC: begin
          if (!div_done) begin
            quo_q   <= quo_nx;
            rem_q   <= rem_nx;
            div_cnt <= div_cnt + CNT_W'(1);
          end else begin
            rpt_q <= rpt_nx;
          end
        end
        ISSUE: begin
          // D is innermost, then row blocks, then K tiles.
          if (fire) begin
            if (!last_d) begin
              d_q <= d_sum[IDX_W-1:0];
            end else begin
              d_q <= '0;
              if (!r_last) begin
                row_q <= r_sum[DIM_W-1:0];
              end else begin
                row_q <= '0;
                if (!k_last) k_q <= k_sum[IDX_W-1:0];
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Command fields read as zero whenever no command is being offered.
  assign tile_valid_o = issue;
  assign k_idx_o      = issue ? k_q : '0;
  assign d_idx_o      = issue ? (is_dw ? k_q : d_q) : '0;
  assign cur_K_o      = issue ? cur_k : '0;
  assign cur_D_o      = issue ? (is_dw ? cur_k : cur_d) : '0;
  assign row_start_o  = issue ? row_q : '0;
  assign rows_o       = issue ? rows : '0;
  assign first_d_o    = issue && first_d;
  assign last_d_o     = issue && last_d;
  assign busy_o       = (state != IDLE);
  assign done_o       = (state == DONE);
  assign err_o        = err_q;

endmodule
